// File: rtl/apb4_master_bridge_pkg.sv
// apb_pkg: definitions shared by the APB4 requester bridge and its bench.
// Holds the transfer FSM state type, the command/response records at the
// default 32-bit bus geometry, and the PPROT bit positions.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  // PPROT bit positions (APB4)
  localparam int PPROT_PRIV_BIT   = 0;
  localparam int PPROT_NONSEC_BIT = 1;
  localparam int PPROT_INSTR_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb4_master_bridge_if.sv
// apb4_master_bridge_if: command/response handshake plus the APB4 bus.
// Modport master is the bridge's view (drives cmd_ready, rsp_*, PSEL..PPROT);
// modport slave is the opposite side (command source, response sink, APB
// completer).
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;
  logic [2:0]              cmd_prot;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb4_master_bridge_timeout_cnt.sv
// apb_timeout_cnt: up-counter with synchronous clear and load, count enable
// and a terminal-count flag.
// Ports: clk, rst_n (async active-low), clear, load/load_val, enable,
//        tc (high while count equals TERMINAL).
module apb_timeout_cnt #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: APB4 requester. Turns one valid/ready command into an
// APB4 SETUP/ACCESS transfer and returns the result on a valid/ready
// response channel. One transfer in flight; a PREADY timeout aborts a hung
// completer.
// Ports: PCLK, PRESETn (async active-low), bus (apb4_master_bridge_if.master):
//        cmd_* in / cmd_ready out, rsp_* out / rsp_ready in, APB4 P* signals.
module apb4_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 8
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb4_master_bridge_if.master bus
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << ADDR_LSB) - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // tc fires on the last permitted wait cycle, so the increment that would
  // reach TIMEOUT_CYCLES is the one that aborts.
  localparam logic [COUNT_WIDTH-1:0] TC_VAL =
    TIMEOUT_EN ? COUNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_t              state;
  logic                    out_of_reset;
  logic                    psel, penable, pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    cmd_ready, accept, wait_tc;

  // cmd_ready stays low until the first clock after reset release; in RESP a
  // new command can only be taken together with the current response.
  assign cmd_ready = ((state == IDLE) && out_of_reset) ||
                     ((state == RESP) && bus.rsp_ready);
  assign accept    = bus.cmd_valid && cmd_ready;

  apb_timeout_cnt #(
    .WIDTH    (COUNT_WIDTH),
    .TERMINAL (TC_VAL)
  ) u_timeout_cnt (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clear    (accept),
    .load     (1'b0),
    .load_val ('0),
    .enable   ((state == ACCESS) && !bus.PREADY),
    .tc       (wait_tc)
  );

  // Transfer FSM with registered bus and response outputs. A command is
  // loaded straight into the APB output registers on acceptance, so those
  // keep their last values while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      pstrb        <= '0;
      pprot        <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: ;
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= bus.PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
            state       <= RESP;
          end else if (TIMEOUT_EN && wait_tc) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Acceptance (from IDLE or RESP) overrides the state chosen above.
      if (accept) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= bus.cmd_write;
        paddr   <= bus.cmd_addr & ADDR_MASK;
        pprot   <= bus.cmd_prot;
        pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
        pstrb   <= bus.cmd_write ? bus.cmd_strb : '0;
        state   <= SETUP;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.rsp_timeout = rsp_timeout;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PADDR       = paddr;
  assign bus.PWDATA      = pwdata;
  assign bus.PSTRB       = pstrb;
  assign bus.PPROT       = pprot;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: self-checking bench for apb4_master_bridge.
// Acts as command source, response sink and APB completer; expected values
// come from hand-written vector tables and a transfer-level reference model.
module tb_apb4_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int CW = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;

  apb4_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb4_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    apb_cmd_t    cmd;
    int          waits;
    bit          slverr;
    logic [31:0] prdata;
    int          rspDelay;
    logic [31:0] expPaddr;
    logic [31:0] expPwdata;
    logic [3:0]  expPstrb;
    int          expAccess;
    apb_rsp_t    expRsp;
  } vecT;

  int compared = 0;
  int mismatched = 0;
  vecT vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vecT mkVec(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot, input int waits,
                                input bit slverr, input logic [31:0] prdata, input int rspDelay,
                                input logic [31:0] ePaddr, input logic [31:0] ePwdata,
                                input logic [3:0] ePstrb, input int eAccess,
                                input logic [31:0] eRdata, input bit eErr, input bit eTo);
    vecT v;
    v.cmd.write = w; v.cmd.addr = addr; v.cmd.wdata = wdata; v.cmd.strb = strb; v.cmd.prot = prot;
    v.waits = waits; v.slverr = slverr; v.prdata = prdata; v.rspDelay = rspDelay;
    v.expPaddr = ePaddr; v.expPwdata = ePwdata; v.expPstrb = ePstrb; v.expAccess = eAccess;
    v.expRsp.rdata = eRdata; v.expRsp.err = eErr; v.expRsp.timeout = eTo;
    return v;
  endfunction

  // Transfer-level model: what the completer does decides how long ACCESS
  // lasts and what comes back.
  function automatic vecT refModel(input vecT v);
    vecT r;
    bit timedOut;
    r = v;
    timedOut = (TO != 0) && (v.waits >= TO);
    r.expAccess = timedOut ? TO : v.waits + 1;
    r.expRsp.timeout = timedOut;
    r.expRsp.err = timedOut || v.slverr;
    r.expRsp.rdata = (!v.cmd.write && !r.expRsp.err) ? v.prdata : 32'h0;
    r.expPaddr = (v.cmd.addr / 4) * 4;
    r.expPwdata = v.cmd.write ? v.cmd.wdata : 32'h0;
    r.expPstrb = v.cmd.write ? v.cmd.strb : 4'h0;
    return r;
  endfunction

  task automatic idleInputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_strb = '0; bus.cmd_prot = '0; bus.rsp_ready = 1'b0;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
  endtask

  task automatic resetDut();
    idleInputs();
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic driveCmd(input apb_cmd_t c);
    bus.cmd_valid = 1'b1; bus.cmd_write = c.write; bus.cmd_addr = c.addr;
    bus.cmd_wdata = c.wdata; bus.cmd_strb = c.strb; bus.cmd_prot = c.prot;
  endtask

  task automatic checkBus(input vecT v, input string tag);
    checkOutput($sformatf("%s PADDR", tag), 64'(bus.PADDR), 64'(v.expPaddr));
    checkOutput($sformatf("%s PWRITE", tag), 64'(bus.PWRITE), 64'(v.cmd.write));
    checkOutput($sformatf("%s PPROT", tag), 64'(bus.PPROT), 64'(v.cmd.prot));
    checkOutput($sformatf("%s PWDATA", tag), 64'(bus.PWDATA), 64'(v.expPwdata));
    checkOutput($sformatf("%s PSTRB", tag), 64'(bus.PSTRB), 64'(v.expPstrb));
  endtask

  // One complete transfer from the IDLE state: issue, play completer with the
  // vector's wait count, check every bus cycle, then stall and drain the
  // response.
  task automatic applyStimulus(input vecT v, input string tag);
    int lat, setupCnt, accessCnt;
    bit accepted, done;
    logic [63:0] notSeen;
    @(negedge PCLK);
    driveCmd(v.cmd);
    bus.rsp_ready = 1'b0;
    accepted = 1'b0;
    for (int g = 0; g < 20 && !accepted; g++) begin
      #1;
      if (bus.cmd_ready === 1'b1) accepted = 1'b1;
      @(negedge PCLK);
    end
    bus.cmd_valid = 1'b0;
    if (!accepted) begin
      notSeen = 64'h0;
      checkOutput($sformatf("%s accept", tag), notSeen, 64'h1);
      resetDut();
      return;
    end
    setupCnt = 0; accessCnt = 0; done = 1'b0; lat = 1;
    while (!done && lat < 100) begin
      if (bus.rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
          setupCnt++;
          checkBus(v, $sformatf("%s setup", tag));
          bus.PREADY = 1'($urandom_range(0, 1));
          bus.PSLVERR = 1'($urandom_range(0, 1));
          bus.PRDATA = $urandom;
        end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
          accessCnt++;
          checkBus(v, $sformatf("%s access", tag));
          if (accessCnt > v.waits) begin
            bus.PREADY = 1'b1; bus.PSLVERR = v.slverr; bus.PRDATA = v.prdata;
          end else begin
            bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom_range(0, 1)); bus.PRDATA = $urandom;
          end
        end else begin
          bus.PREADY = 1'($urandom_range(0, 1));
          bus.PSLVERR = 1'($urandom_range(0, 1));
        end
        @(negedge PCLK);
        lat++;
      end
    end
    checkOutput($sformatf("%s rsp_valid seen", tag), 64'(done), 64'h1);
    if (!done) begin
      resetDut();
      return;
    end
    checkOutput($sformatf("%s setup cycles", tag), 64'(setupCnt), 64'h1);
    checkOutput($sformatf("%s access cycles", tag), 64'(accessCnt), 64'(v.expAccess));
    checkOutput($sformatf("%s rsp latency", tag), 64'(lat), 64'(v.expAccess + 2));
    checkOutput($sformatf("%s PSEL in resp", tag), 64'(bus.PSEL), 64'h0);
    checkOutput($sformatf("%s PENABLE in resp", tag), 64'(bus.PENABLE), 64'h0);
    checkOutput($sformatf("%s cmd_ready stalled", tag), 64'(bus.cmd_ready), 64'h0);
    checkOutput($sformatf("%s rsp_rdata", tag), 64'(bus.rsp_rdata), 64'(v.expRsp.rdata));
    checkOutput($sformatf("%s rsp_err", tag), 64'(bus.rsp_err), 64'(v.expRsp.err));
    checkOutput($sformatf("%s rsp_timeout", tag), 64'(bus.rsp_timeout), 64'(v.expRsp.timeout));
    for (int d = 0; d < v.rspDelay; d++) begin
      @(negedge PCLK);
      checkOutput($sformatf("%s rsp_valid held", tag), 64'(bus.rsp_valid), 64'h1);
      checkOutput($sformatf("%s rsp_rdata held", tag), 64'(bus.rsp_rdata), 64'(v.expRsp.rdata));
      checkOutput($sformatf("%s PSEL while stalled", tag), 64'(bus.PSEL), 64'h0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput($sformatf("%s cmd_ready with rsp_ready", tag), 64'(bus.cmd_ready), 64'h1);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    checkOutput($sformatf("%s rsp_valid dropped", tag), 64'(bus.rsp_valid), 64'h0);
    checkOutput($sformatf("%s idle PSEL", tag), 64'(bus.PSEL), 64'h0);
    checkOutput($sformatf("%s idle cmd_ready", tag), 64'(bus.cmd_ready), 64'h1);
  endtask

  // Two queued commands with the first response held off for two cycles.
  task automatic backToBack();
    apb_cmd_t a, b;
    a.write = 1'b0; a.addr = 32'h80; a.wdata = 32'h0; a.strb = 4'h0; a.prot = 3'd0;
    b.write = 1'b1; b.addr = 32'h84; b.wdata = 32'hCAFEF00D; b.strb = 4'h3; b.prot = 3'd2;
    @(negedge PCLK);
    driveCmd(a);
    bus.rsp_ready = 1'b0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h11112222;
    #1 checkOutput("b2b first accept", 64'(bus.cmd_ready), 64'h1);
    @(negedge PCLK);
    driveCmd(b);
    checkOutput("b2b cmd_ready in setup", 64'(bus.cmd_ready), 64'h0);
    @(negedge PCLK);
    checkOutput("b2b first access", 64'(bus.PENABLE), 64'h1);
    for (int s = 0; s < 2; s++) begin
      @(negedge PCLK);
      checkOutput("b2b stalled rsp_valid", 64'(bus.rsp_valid), 64'h1);
      checkOutput("b2b stalled rsp_rdata", 64'(bus.rsp_rdata), 64'h11112222);
      checkOutput("b2b stalled PSEL", 64'(bus.PSEL), 64'h0);
      checkOutput("b2b stalled cmd_ready", 64'(bus.cmd_ready), 64'h0);
    end
    @(negedge PCLK);
    checkOutput("b2b still stalled PSEL", 64'(bus.PSEL), 64'h0);
    bus.rsp_ready = 1'b1;
    #1 checkOutput("b2b cmd_ready in resp", 64'(bus.cmd_ready), 64'h1);
    @(negedge PCLK);
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
    checkOutput("b2b second setup PSEL", 64'(bus.PSEL), 64'h1);
    checkOutput("b2b second setup PENABLE", 64'(bus.PENABLE), 64'h0);
    checkOutput("b2b second PADDR", 64'(bus.PADDR), 64'h84);
    checkOutput("b2b second PWDATA", 64'(bus.PWDATA), 64'hCAFEF00D);
    checkOutput("b2b first rsp_valid dropped", 64'(bus.rsp_valid), 64'h0);
    @(negedge PCLK);
    checkOutput("b2b second access PENABLE", 64'(bus.PENABLE), 64'h1);
    checkOutput("b2b second PSTRB", 64'(bus.PSTRB), 64'h3);
    @(negedge PCLK);
    checkOutput("b2b second rsp_valid", 64'(bus.rsp_valid), 64'h1);
    checkOutput("b2b second rsp_err", 64'(bus.rsp_err), 64'h0);
    checkOutput("b2b second rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    checkOutput("b2b drained", 64'(bus.rsp_valid), 64'h0);
  endtask

  // Reset asserted while ACCESS is waiting on PREADY.
  task automatic resetMidAccess();
    apb_cmd_t c;
    c.write = 1'b0; c.addr = 32'h200; c.wdata = 32'h0; c.strb = 4'h0; c.prot = 3'd0;
    @(negedge PCLK);
    driveCmd(c);
    bus.PREADY = 1'b0;
    #1 checkOutput("rst-mid accept", 64'(bus.cmd_ready), 64'h1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("rst-mid waiting PENABLE", 64'(bus.PENABLE), 64'h1);
    PRESETn = 1'b0;
    #1;
    checkOutput("rst-mid async PSEL", 64'(bus.PSEL), 64'h0);
    checkOutput("rst-mid async PENABLE", 64'(bus.PENABLE), 64'h0);
    checkOutput("rst-mid async rsp_valid", 64'(bus.rsp_valid), 64'h0);
    checkOutput("rst-mid async cmd_ready", 64'(bus.cmd_ready), 64'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("rst-mid no response", 64'(bus.rsp_valid), 64'h0);
    checkOutput("rst-mid cmd_ready back", 64'(bus.cmd_ready), 64'h1);
    applyStimulus(mkVec(1'b1, 32'h300, 32'hA5A5A5A5, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0,
                        32'h300, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 1'b0, 1'b0), "post-reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    PRESETn = 1'b0;
    #2;
    checkOutput("reset cmd_ready", 64'(bus.cmd_ready), 64'h0);
    checkOutput("reset PSEL", 64'(bus.PSEL), 64'h0);
    checkOutput("reset PENABLE", 64'(bus.PENABLE), 64'h0);
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'h0);
    checkOutput("reset PADDR", 64'(bus.PADDR), 64'h0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    #1 checkOutput("cmd_ready before first rise", 64'(bus.cmd_ready), 64'h0);
    @(negedge PCLK);
    checkOutput("cmd_ready after first rise", 64'(bus.cmd_ready), 64'h1);

    //            w     addr          wdata          strb  prot  wait slv  prdata         dly  paddr         pwdata         pstrb acc rdata          err   to
    vecs[0] = mkVec(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 3'd0, 0,  1'b0, 32'h0,        0, 32'h10,   32'hDEADBEEF, 4'hF, 1,  32'h0,        1'b0, 1'b0);
    vecs[1] = mkVec(1'b0, 32'h20,   32'h55555555, 4'hF, 3'd0, 3,  1'b0, 32'h12345678, 1, 32'h20,   32'h0,        4'h0, 4,  32'h12345678, 1'b0, 1'b0);
    vecs[2] = mkVec(1'b1, 32'hFC,   32'h0BADF00D, 4'h3, 3'd2, 0,  1'b1, 32'h0,        0, 32'hFC,   32'h0BADF00D, 4'h3, 1,  32'h0,        1'b1, 1'b0);
    vecs[3] = mkVec(1'b0, 32'h40,   32'h0,        4'h0, 3'd1, 30, 1'b0, 32'hFFFFFFFF, 0, 32'h40,   32'h0,        4'h0, 16, 32'h0,        1'b1, 1'b1);
    vecs[4] = mkVec(1'b0, 32'h44,   32'h0,        4'h0, 3'd0, 2,  1'b1, 32'hAAAA5555, 2, 32'h44,   32'h0,        4'h0, 3,  32'h0,        1'b1, 1'b0);
    vecs[5] = mkVec(1'b1, 32'h1003, 32'h01020304, 4'h5, 3'd5, 1,  1'b0, 32'h0,        0, 32'h1000, 32'h01020304, 4'h5, 2,  32'h0,        1'b0, 1'b0);
    vecs[6] = mkVec(1'b0, 32'h80,   32'h0,        4'h0, 3'd0, 15, 1'b0, 32'hC0FFEE00, 0, 32'h80,   32'h0,        4'h0, 16, 32'hC0FFEE00, 1'b0, 1'b0);
    vecs[7] = mkVec(1'b0, 32'h84,   32'h0,        4'h0, 3'd0, 16, 1'b0, 32'h1,        1, 32'h84,   32'h0,        4'h0, 16, 32'h0,        1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    backToBack();
    resetMidAccess();

    for (int i = 0; i < 40; i++) begin
      vecT v;
      v.cmd.write = 1'($urandom_range(0, 1));
      v.cmd.addr = $urandom;
      v.cmd.wdata = $urandom;
      v.cmd.strb = 4'($urandom_range(0, 15));
      v.cmd.prot = 3'($urandom_range(0, 7));
      v.waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      v.slverr = ($urandom_range(0, 3) == 0);
      v.prdata = $urandom;
      v.rspDelay = int'($urandom_range(0, 3));
      applyStimulus(refModel(v), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
